// File: rtl/fmac_pktctrl_rd.sv
// fmac_pktctrl_rd: read-side consumer of the packet-control FIFO.
// Pops 4-byte control records through a non-FWFT read port, assembles a
// descriptor {flags, len, tag} and hands it out over valid/ready.
// Optional macro FMAC_PKTCTRL_CHK_EN: byte3 is a check byte (b0^b1^b2)
// and a mismatch also flags the descriptor as malformed.
module fmac_pktctrl_rd #(
  parameter int unsigned REC_BYTES = 4,
  parameter logic [15:0] MAX_LEN   = 16'd9600,
  parameter int unsigned USEDW_W   = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               rdreq,
  input  logic [7:0]         q,
  input  logic               rdempty,
  input  logic [USEDW_W-1:0] rdusedw,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [7:0]         desc_flags,
  output logic [15:0]        desc_len,
  output logic [7:0]         desc_tag,
  output logic               desc_err,
  output logic [15:0]        err_cnt
);

  typedef enum logic [1:0] {IDLE, RD, CHECK, HOLD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  iss_q, iss_d;
  logic        cap_vld_q, cap_vld_d;
  logic [1:0]  cap_idx_q, cap_idx_d;
  logic [7:0]  byte_q [0:3];
  logic [7:0]  byte_d [0:3];
  logic        valid_q, valid_d;
  logic [7:0]  flags_q, flags_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  tag_q, tag_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        rdreq_c;
  logic [15:0] rec_len;
  logic        len_bad;
  logic        chk_bad;

  assign rec_len = {byte_q[1], byte_q[2]};
  assign len_bad = (rec_len == 16'd0) || (rec_len > MAX_LEN);
`ifdef FMAC_PKTCTRL_CHK_EN
  assign chk_bad = (byte_q[3] != (byte_q[0] ^ byte_q[1] ^ byte_q[2]));
`else
  assign chk_bad = 1'b0;
`endif

  // Next-state and datapath: issue 4 reads, capture one cycle behind, then
  // build the descriptor and hold it until accepted.
  always_comb begin
    state_d   = state_q;
    iss_d     = iss_q;
    valid_d   = valid_q;
    flags_d   = flags_q;
    len_d     = len_q;
    tag_d     = tag_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    for (int unsigned i = 0; i < 4; i++) byte_d[i] = byte_q[i];

    rdreq_c   = (state_q == RD) && (iss_q < 3'd4);
    cap_vld_d = rdreq_c;
    cap_idx_d = iss_q[1:0];
    if (cap_vld_q) byte_d[cap_idx_q] = q;

    case (state_q)
      IDLE: begin
        iss_d = '0;
        if (enable && !rdempty && (rdusedw >= USEDW_W'(REC_BYTES))) state_d = RD;
      end
      RD: begin
        if (rdreq_c) iss_d = iss_q + 3'd1;
        // Leave only once the last byte has landed (one cycle after its rdreq).
        if (cap_vld_q && (cap_idx_q == 2'd3)) state_d = CHECK;
      end
      CHECK: begin
        flags_d = byte_q[0];
        len_d   = rec_len;
        tag_d   = byte_q[3];
        err_d   = len_bad || chk_bad;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (desc_ready) begin
          valid_d = 1'b0;
          if (err_q && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters, byte slots and descriptor registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      for (int unsigned i = 0; i < 4; i++) byte_q[i] <= '0;
      valid_q   <= 1'b0;
      flags_q   <= '0;
      len_q     <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      iss_q     <= iss_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      for (int unsigned i = 0; i < 4; i++) byte_q[i] <= byte_d[i];
      valid_q   <= valid_d;
      flags_q   <= flags_d;
      len_q     <= len_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rdreq      = rdreq_c;
  assign desc_valid = valid_q;
  assign desc_flags = flags_q;
  assign desc_len   = len_q;
  assign desc_tag   = tag_q;
  assign desc_err   = err_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_fmac_pktctrl_rd.sv
// Directed bench for fmac_pktctrl_rd with a simple non-FWFT FIFO model.
module tb_fmac_pktctrl_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        rdreq;
  logic [7:0]  q;
  logic        rdempty;
  logic [12:0] rdusedw;
  logic        desc_valid;
  logic        desc_ready;
  logic [7:0]  desc_flags;
  logic [15:0] desc_len;
  logic [7:0]  desc_tag;
  logic        desc_err;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;

  fmac_pktctrl_rd #(.REC_BYTES(4), .MAX_LEN(16'd9600), .USEDW_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rdreq(rdreq), .q(q),
    .rdempty(rdempty), .rdusedw(rdusedw), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .desc_flags(desc_flags), .desc_len(desc_len),
    .desc_tag(desc_tag), .desc_err(desc_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: write side owned by the initial block, read side here.
  logic [7:0]  mem [0:255];
  logic [12:0] wp = '0;
  logic [12:0] rp = '0;
  logic        fifo_clr = 1'b0;

  assign rdusedw = wp - rp;
  assign rdempty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_clr) rp <= wp;
    else if (rdreq && (wp != rp)) begin
      q  <= mem[rp[7:0]];
      rp <= rp + 13'd1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wp[7:0]] = b;
    wp = wp + 13'd1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One record with desc_ready=1: checks rdreq burst, N+6 latency, fields, err_cnt.
  task automatic rec(input string tag, input logic [7:0] b0, b1, b2, b3,
                     input logic exp_err, input logic [15:0] exp_cnt);
    bit found;
    found = 0;
    push(b0); push(b1); push(b2); push(b3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdreq) begin found = 1; break; end
    end
    chk({tag, "_start"}, 48'(found), 48'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, "_rdreq_hi"}, 48'(rdreq), 48'd1);
    end
    @(negedge clk); chk({tag, "_rdreq_lo"}, 48'(rdreq), 48'd0);
    @(negedge clk); chk({tag, "_valid_n5"}, 48'(desc_valid), 48'd0);
    @(negedge clk); chk({tag, "_valid_n6"}, 48'(desc_valid), 48'd1);
    chk({tag, "_fields"}, 48'({desc_flags, desc_len, desc_tag, desc_err}),
        48'({b0, b1, b2, b3, exp_err}));
    @(negedge clk); chk({tag, "_valid_n7"}, 48'(desc_valid), 48'd0);
    chk({tag, "_errcnt"}, 48'(err_cnt), 48'(exp_cnt));
  endtask

  initial begin
    int  cnt;
    bit  found;
    rst_n = 1'b0; enable = 1'b0; desc_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdreq", 48'(rdreq), 48'd0);
    chk("rst_outs", 48'({desc_valid, desc_flags, desc_len, desc_tag, desc_err}), 48'd0);
    chk("rst_errcnt", 48'(err_cnt), 48'd0);

    // Empty FIFO with enable: nothing happens.
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("empty_idle", 48'({rdreq, desc_valid}), 48'd0);
    end
    chk("empty_errcnt", 48'(err_cnt), 48'd0);

    // Basic record.
    rec("basic", 8'h01, 8'h05, 8'hDC, 8'hD8, 1'b0, 16'd0);

    // Partial record never starts; 4th byte starts it; then backpressure.
    push(8'h02); push(8'h00); push(8'h40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("partial_no_rdreq", 48'(rdreq), 48'd0);
    end
    desc_ready = 1'b0;
    push(8'h42);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (desc_valid) begin found = 1; break; end
    end
    chk("bp_valid", 48'(found), 48'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", 48'({desc_valid, desc_flags, desc_len, desc_tag, desc_err}),
          48'({1'b1, 8'h02, 16'h0040, 8'h42, 1'b0}));
    end
    desc_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", 48'(desc_valid), 48'd0);

    // Malformed lengths.
    rec("len0", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 16'd1);
    rec("len9601", 8'h00, 8'h25, 8'h81, 8'hA4, 1'b1, 16'd2);

    // Bad check byte: only an error when the check feature is built in.
`ifdef FMAC_PKTCTRL_CHK_EN
    rec("chkbyte", 8'h01, 8'h05, 8'hDC, 8'h00, 1'b1, 16'd3);
`else
    rec("chkbyte", 8'h01, 8'h05, 8'hDC, 8'h00, 1'b0, 16'd2);
`endif

    // Reset mid-record at the 2nd rdreq of the second queued record.
    push(8'h01); push(8'h05); push(8'hDC); push(8'hD8);
    push(8'h01); push(8'h05); push(8'hDC); push(8'hD8);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rdreq) cnt++;
      if (cnt == 6) break;
    end
    chk("abort_reach", 48'(cnt), 48'd6);
    rst_n = 1'b0; fifo_clr = 1'b1;
    @(negedge clk);
    chk("abort_rdreq", 48'(rdreq), 48'd0);
    chk("abort_valid", 48'(desc_valid), 48'd0);
    chk("abort_errcnt", 48'(err_cnt), 48'd0);
    rst_n = 1'b1; fifo_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_idle", 48'({rdreq, desc_valid}), 48'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
